// File: rtl/mem_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_store_unit_pkg
//   Shared utility definitions for the CPU data path.
//   - Uop         : micro-op encoding seen by the load/store units.
//   - StoreDest   : decoded target of a data-memory address.
//   - DCACHE_WORDS: word addresses 0..DCACHE_WORDS-1 live in the D-cache.
//   - GPIO_ADDR   : word address of the GPIO output register.
//   The load-side return mux decodes the same map, so both directions
//   take their constants from here.
// ---------------------------------------------------------------------------
package mem_store_unit_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ALU = 3'd1,
    LDR = 3'd2,
    STR = 3'd3
  } Uop;

  typedef enum logic [1:0] {
    DEST_DCACHE = 2'd0,
    DEST_GPIO   = 2'd1,
    DEST_NONE   = 2'd2
  } StoreDest;

  // Word 31 is deliberately left out of the D-cache range.
  localparam logic [31:0] DCACHE_WORDS = 32'd31;
  localparam logic [31:0] GPIO_ADDR    = 32'd32;

endpackage

// File: rtl/mem_store_unit.sv
// ---------------------------------------------------------------------------
// mem_store_unit
//   Store-side router for STR micro-ops. Decodes the store word address and
//   sends the write to the D-cache (req/ack handshake, with timeout), to the
//   memory-mapped GPIO output register, or reports a bus error.
//
// Parameters
//   TIMEOUT    : cycles to wait for dc_ack before dropping the write (1..255)
//   GPIO_RESET : gpio_out value after reset
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   uop, valid          : current micro-op and its valid flag
//   addr, wdata         : store word address and data
//   stall               : hold the pipeline (combinational)
//   dc_we               : D-cache write request, held until ack or timeout
//   dc_addr, dc_wdata   : latched D-cache word index and data
//   dc_ack              : single-cycle D-cache accept pulse
//   gpio_out, gpio_wr   : GPIO output register and its update pulse
//   bus_error           : pulse for unmapped address or D-cache timeout
// ---------------------------------------------------------------------------
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] GPIO_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  Uop          uop,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        dc_we,
  output logic [4:0]  dc_addr,
  output logic [31:0] dc_wdata,
  input  logic        dc_ack,
  output logic [31:0] gpio_out,
  output logic        gpio_wr,
  output logic        bus_error
);

  typedef enum logic {
    IDLE    = 1'b0,
    DC_WAIT = 1'b1
  } StoreState;

  // The wait counter starts at 0 in the first DC_WAIT cycle, so the last
  // permitted cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  function automatic StoreDest decodeAddr(input logic [31:0] a);
    if (a < DCACHE_WORDS) begin
      return DEST_DCACHE;
    end else if (a == GPIO_ADDR) begin
      return DEST_GPIO;
    end else begin
      return DEST_NONE;
    end
  endfunction

  StoreState   r_state;
  StoreState   w_nextState;
  logic [7:0]  r_waitCount;
  logic [4:0]  r_dcAddr;
  logic [31:0] r_dcWdata;
  logic [31:0] r_gpioOut;
  logic        r_gpioWr;
  logic        r_busError;

  logic        w_request;
  StoreDest    w_dest;
  logic        w_timeoutHit;
  logic        w_stall;

  // Next-state and stall decode. Requests are only looked at in IDLE; the
  // ack/timeout cycle releases stall so the pipeline advances exactly once
  // per store, and the still-present store is not re-accepted because the
  // FSM has not yet left DC_WAIT.
  always_comb begin
    w_request    = valid && (uop == STR);
    w_dest       = decodeAddr(addr);
    w_timeoutHit = (r_state == DC_WAIT) && !dc_ack && (r_waitCount == TIMEOUT_LAST);
    w_nextState  = r_state;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_request && (w_dest == DEST_DCACHE)) begin
          w_nextState = DC_WAIT;
          w_stall     = 1'b1;
        end
      end
      DC_WAIT: begin
        if (dc_ack || w_timeoutHit) begin
          w_nextState = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, latched D-cache request, GPIO register and the registered
  // one-cycle pulses. bus_error is registered so it always lands one cycle
  // after its cause, whether that is an unmapped address or a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_waitCount <= 8'd0;
      r_dcAddr    <= 5'd0;
      r_dcWdata   <= 32'd0;
      r_gpioOut   <= GPIO_RESET;
      r_gpioWr    <= 1'b0;
      r_busError  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_gpioWr   <= 1'b0;
      r_busError <= w_timeoutHit;
      if ((r_state == IDLE) && w_request) begin
        case (w_dest)
          DEST_DCACHE: begin
            r_dcAddr    <= addr[4:0];
            r_dcWdata   <= wdata;
            r_waitCount <= 8'd0;
          end
          DEST_GPIO: begin
            r_gpioOut <= wdata;
            r_gpioWr  <= 1'b1;
          end
          default: begin
            r_busError <= 1'b1;
          end
        endcase
      end else if ((r_state == DC_WAIT) && !dc_ack) begin
        r_waitCount <= r_waitCount + 8'd1;
      end
    end
  end

  assign stall     = w_stall;
  assign dc_we     = (r_state == DC_WAIT);
  assign dc_addr   = r_dcAddr;
  assign dc_wdata  = r_dcWdata;
  assign gpio_out  = r_gpioOut;
  assign gpio_wr   = r_gpioWr;
  assign bus_error = r_busError;

endmodule

// File: tb/tb_mem_store_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_store_unit
//   Self-checking bench for mem_store_unit. Each store is described as a
//   transaction (target, data, ack delay) and its cycle-by-cycle outputs are
//   predicted from the address map and handshake timing; the GPIO register
//   value is tracked in a model variable.
// ---------------------------------------------------------------------------
module tb_mem_store_unit;
  import mem_store_unit_pkg::*;

  localparam int          TIMEOUT    = 15;
  localparam logic [31:0] GPIO_RESET = 32'h1234_5678;

  logic        clk;
  logic        reset;
  Uop          uop;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        dcWe;
  logic [4:0]  dcAddr;
  logic [31:0] dcWdata;
  logic        dcAck;
  logic [31:0] gpioOut;
  logic        gpioWr;
  logic        busError;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] modelGpio;

  mem_store_unit #(
    .TIMEOUT   (TIMEOUT),
    .GPIO_RESET(GPIO_RESET)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uop      (uop),
    .valid    (valid),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .dc_we    (dcWe),
    .dc_addr  (dcAddr),
    .dc_wdata (dcWdata),
    .dc_ack   (dcAck),
    .gpio_out (gpioOut),
    .gpio_wr  (gpioWr),
    .bus_error(busError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cycle: inputs change 1 time unit after the rising edge and outputs
  // are sampled 1 unit later, well away from the next edge.
  task automatic driveCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; uop = NOP; addr = '0; wdata = '0; dcAck = 1'b0;
    repeat (2) driveCycle();
    #1;
    vectors++; if (dcWe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dc_we got %b want 0", dcWe); end
    vectors++; if (dcAddr !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_dc_addr got %0d want 0", dcAddr); end
    vectors++; if (dcWdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_dc_wdata got %h want 0", dcWdata); end
    vectors++; if (gpioOut !== GPIO_RESET) begin miscompares++; $display("[TB] FAIL reset_gpio_out got %h want %h", gpioOut, GPIO_RESET); end
    vectors++; if (gpioWr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_gpio_wr got %b want 0", gpioWr); end
    vectors++; if (busError !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bus_error got %b want 0", busError); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    driveCycle();
    reset = 1'b0;
    modelGpio = GPIO_RESET;
  endtask

  // A single-cycle store that never touches the D-cache: GPIO, unmapped
  // STR, or any non-STR uop. A random dc_ack is driven to show it is
  // ignored outside a D-cache write.
  task automatic runSimpleStore(input Uop u, input logic [31:0] a, input logic [31:0] d, input string name);
    bit isStr, toGpio, unmapped;
    isStr    = (u == STR);
    toGpio   = isStr && (a == 32'd32);
    unmapped = isStr && (a >= 32'd31) && (a != 32'd32);
    driveCycle();
    valid = 1'b1; uop = u; addr = a; wdata = d; dcAck = 1'($urandom_range(0, 1));
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL %s stall0 got %b want 0", name, stall); end
    vectors++; if (dcWe !== 1'b0) begin miscompares++; $display("[TB] FAIL %s dc_we0 got %b want 0", name, dcWe); end
    vectors++; if (busError !== 1'b0) begin miscompares++; $display("[TB] FAIL %s bus_error0 got %b want 0", name, busError); end
    driveCycle();
    valid = 1'b0; dcAck = 1'b0;
    #1;
    if (toGpio) modelGpio = d;
    vectors++; if (gpioWr !== toGpio) begin miscompares++; $display("[TB] FAIL %s gpio_wr got %b want %b", name, gpioWr, toGpio); end
    vectors++; if (gpioOut !== modelGpio) begin miscompares++; $display("[TB] FAIL %s gpio_out got %h want %h", name, gpioOut, modelGpio); end
    vectors++; if (busError !== unmapped) begin miscompares++; $display("[TB] FAIL %s bus_error got %b want %b", name, busError, unmapped); end
    vectors++; if (dcWe !== 1'b0) begin miscompares++; $display("[TB] FAIL %s dc_we1 got %b want 0", name, dcWe); end
  endtask

  // A D-cache store with dc_ack in cycle ackCycle after accept (0 = never).
  // The write is outstanding for min(ackCycle, TIMEOUT) cycles; a missing
  // ack produces a bus_error the cycle after the last wait cycle.
  task automatic runDcStore(input logic [31:0] a, input logic [31:0] d, input int ackCycle, input string name);
    bit timedOut;
    int lastCycle;
    bit expStall, expWe, expErr;
    timedOut  = (ackCycle == 0) || (ackCycle > TIMEOUT);
    lastCycle = timedOut ? TIMEOUT : ackCycle;
    for (int c = 0; c <= lastCycle + 1; c++) begin
      driveCycle();
      valid = (c <= lastCycle); uop = STR; addr = a; wdata = d;
      dcAck = !timedOut && (c == ackCycle);
      #1;
      expStall = (c < lastCycle);
      expWe    = (c >= 1) && (c <= lastCycle);
      expErr   = timedOut && (c == lastCycle + 1);
      vectors++; if (stall !== expStall) begin miscompares++; $display("[TB] FAIL %s stall c%0d got %b want %b", name, c, stall, expStall); end
      vectors++; if (dcWe !== expWe) begin miscompares++; $display("[TB] FAIL %s dc_we c%0d got %b want %b", name, c, dcWe, expWe); end
      vectors++; if (busError !== expErr) begin miscompares++; $display("[TB] FAIL %s bus_error c%0d got %b want %b", name, c, busError, expErr); end
      vectors++; if (gpioWr !== 1'b0) begin miscompares++; $display("[TB] FAIL %s gpio_wr c%0d got %b want 0", name, c, gpioWr); end
      if (expWe) begin
        vectors++; if (dcAddr !== a[4:0]) begin miscompares++; $display("[TB] FAIL %s dc_addr c%0d got %0d want %0d", name, c, dcAddr, a[4:0]); end
        vectors++; if (dcWdata !== d) begin miscompares++; $display("[TB] FAIL %s dc_wdata c%0d got %h want %h", name, c, dcWdata, d); end
      end
    end
    valid = 1'b0; dcAck = 1'b0;
    vectors++; if (gpioOut !== modelGpio) begin miscompares++; $display("[TB] FAIL %s gpio_out got %h want %h", name, gpioOut, modelGpio); end
  endtask

  task automatic test_gpio();
    runSimpleStore(STR, 32'd32, 32'hA5A5_0001, "gpio_store");
    driveCycle();
    #1;
    vectors++; if (gpioWr !== 1'b0) begin miscompares++; $display("[TB] FAIL gpio_wr_pulse got %b want 0", gpioWr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [4];
    for (int i = 0; i < 4; i++) data[i] = $urandom;
    for (int i = 0; i <= 4; i++) begin
      driveCycle();
      valid = (i < 4); uop = STR; addr = 32'd32; wdata = (i < 4) ? data[i] : 32'd0;
      #1;
      if (i > 0) begin
        modelGpio = data[i-1];
        vectors++; if (gpioOut !== modelGpio) begin miscompares++; $display("[TB] FAIL b2b gpio_out %0d got %h want %h", i, gpioOut, modelGpio); end
        vectors++; if (gpioWr !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b gpio_wr %0d got %b want 1", i, gpioWr); end
      end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b stall %0d got %b want 0", i, stall); end
    end
    valid = 1'b0;
  endtask

  task automatic test_unmapped();
    runSimpleStore(STR, 32'd31, 32'h1111_2222, "unmapped_31");
    runSimpleStore(STR, 32'd100, 32'h3333_4444, "unmapped_100");
  endtask

  task automatic test_non_str();
    runSimpleStore(LDR, 32'd32, 32'hCAFE_0001, "ldr_gpio");
    runSimpleStore(ALU, 32'd32, 32'hCAFE_0002, "alu_gpio");
    runSimpleStore(LDR, 32'd3, 32'hCAFE_0003, "ldr_dc");
    runSimpleStore(ALU, 32'd3, 32'hCAFE_0004, "alu_dc");
  endtask

  task automatic test_reset_mid_wait();
    runSimpleStore(STR, 32'd32, 32'h0000_00FF, "pre_reset_gpio");
    driveCycle();
    valid = 1'b1; uop = STR; addr = 32'd7; wdata = 32'h7777_7777; dcAck = 1'b0;
    driveCycle();
    driveCycle();
    reset = 1'b1;
    driveCycle();
    reset = 1'b0; valid = 1'b0;
    #1;
    modelGpio = GPIO_RESET;
    vectors++; if (dcWe !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wait dc_we got %b want 0", dcWe); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wait stall got %b want 0", stall); end
    vectors++; if (gpioOut !== GPIO_RESET) begin miscompares++; $display("[TB] FAIL rst_wait gpio_out got %h want %h", gpioOut, GPIO_RESET); end
    vectors++; if (busError !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wait bus_error got %b want 0", busError); end
    driveCycle();
    #1;
    vectors++; if (busError !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wait bus_error2 got %b want 0", busError); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind, ack;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: runSimpleStore(STR, 32'd32, $urandom, "rnd_gpio");
        1: begin
          a   = $urandom_range(0, 30);
          ack = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2);
          runDcStore(a, $urandom, ack, "rnd_dc");
        end
        2: begin
          a = $urandom;
          if (a <= 32'd32) a = 32'd31;
          runSimpleStore(STR, a, $urandom, "rnd_unmapped");
        end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 32'd32 : 32'($urandom_range(0, 40));
          runSimpleStore(($urandom_range(0, 1) == 1) ? LDR : ALU, a, $urandom, "rnd_nonstr");
        end
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_gpio();
    runDcStore(32'd5, 32'hDEAD_BEEF, 3, "dc_ack3");
    runDcStore(32'd30, 32'h0BAD_F00D, 1, "dc_ack1");
    test_unmapped();
    runDcStore(32'd0, 32'h5555_AAAA, 0, "dc_timeout");
    runSimpleStore(STR, 32'd32, 32'h0000_1234, "gpio_after_timeout");
    test_non_str();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
